// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
// ----------------
// Central arbiter that shares one PCI bus between N_MASTERS bus masters.
// Requests are sampled every falling clock edge. Ownership rotates round-robin.
// A grant that is never used is revoked after TIMEOUT cycles if somebody else
// is waiting. An idle bus can be parked on PARK_MASTER.
//
// Ports
//   clk          bus clock; all state changes on the falling edge
//   rst          asynchronous active-high reset
//   req          active-low request, one bit per master
//   frame        active-low PCI FRAME#
//   irdy         active-low PCI IRDY#
//   gnt          active-low grant, one bit per master (at most one low)
//   owner        index of the current or last grant holder
//   bus_busy     high while the arbiter tracks a transaction (BUSY state)
//   timeout_evt  one-cycle pulse when an unused grant is revoked
//
// Handshake: a master owns the bus from the cycle its gnt bit is low. It keeps
// the bus for a whole transaction once it drives frame low, and releases it
// when frame and irdy are both sampled high. Moving a grant between two
// different masters always passes through one all-high turnaround cycle.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter bit PARK_EN     = 1'b1,
  parameter int PARK_MASTER = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 frame,
  input  logic                 irdy,
  output logic [N_MASTERS-1:0] gnt,
  output logic [2:0]           owner,
  output logic                 bus_busy,
  output logic                 timeout_evt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARK  = 3'd1,
    ST_GRANT = 3'd2,
    ST_BUSY  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  localparam logic [2:0]           PARK_IDX = 3'(PARK_MASTER);
  localparam logic [2:0]           LAST_IDX = 3'(N_MASTERS - 1);
  localparam logic [7:0]           WAIT_MAX = 8'(TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ALL_HIGH = '1;

  state_t     state;
  logic [2:0] rr_ptr;
  logic [7:0] wait_cnt;
  // Set while BUSY was entered by a transaction we never granted.
  logic       foreign;

  // Active-high request vector padded to 8 bits so any 3-bit index is legal.
  logic [7:0] req_act;
  logic       any_req;
  logic       owner_req;
  logic       other_req;
  logic       bus_idle;
  logic [2:0] winner;
  logic       found;
  logic [3:0] cand;

  // Result of a fresh arbitration, shared by IDLE, TURN and foreign BUSY exit.
  state_t                 arb_state;
  logic [2:0]             arb_owner;
  logic [N_MASTERS-1:0]   arb_gnt;
  logic [2:0]             arb_rr;

  function automatic logic [N_MASTERS-1:0] grant_vec(input logic [2:0] idx);
    logic [N_MASTERS-1:0] v;
    for (int k = 0; k < N_MASTERS; k++) begin
      v[k] = (3'(k) != idx);
    end
    return v;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

  always_comb begin
    req_act                = '0;
    req_act[N_MASTERS-1:0] = ~req;
  end

  assign any_req   = |req_act;
  assign owner_req = req_act[owner];
  assign other_req = |(req_act & ~(8'd1 << owner));
  assign bus_idle  = frame & irdy;
  assign bus_busy  = (state == ST_BUSY);

  // Round-robin search upward from rr_ptr. rr_ptr and i are both below
  // N_MASTERS, so a single conditional subtract implements the wrap.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(N_MASTERS)) cand = cand - 4'(N_MASTERS);
      if (!found && req_act[cand[2:0]]) begin
        winner = cand[2:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    arb_state = ST_IDLE;
    arb_owner = owner;
    arb_gnt   = ALL_HIGH;
    arb_rr    = rr_ptr;
    if (any_req) begin
      arb_state = ST_GRANT;
      arb_owner = winner;
      arb_gnt   = grant_vec(winner);
      arb_rr    = next_idx(winner);
    end else if (PARK_EN) begin
      arb_state = ST_PARK;
      arb_owner = PARK_IDX;
      arb_gnt   = grant_vec(PARK_IDX);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= ALL_HIGH;
      owner       <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      timeout_evt <= 1'b0;
      foreign     <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      unique case (state)
        ST_IDLE, ST_TURN: begin
          if (!frame) begin
            state   <= ST_BUSY;
            foreign <= 1'b1;
            gnt     <= ALL_HIGH;
          end else begin
            state    <= arb_state;
            owner    <= arb_owner;
            gnt      <= arb_gnt;
            rr_ptr   <= arb_rr;
            wait_cnt <= '0;
            foreign  <= 1'b0;
          end
        end

        ST_PARK: begin
          if (!frame) begin
            state   <= ST_BUSY;
            foreign <= 1'b0;
          end else if (any_req && (winner != PARK_IDX)) begin
            state <= ST_TURN;
            gnt   <= ALL_HIGH;
          end else if (req_act[PARK_IDX]) begin
            // Park master asked for the bus it already holds: no turnaround.
            state    <= ST_GRANT;
            wait_cnt <= '0;
            rr_ptr   <= next_idx(PARK_IDX);
          end
        end

        ST_GRANT: begin
          if (!frame) begin
            state    <= ST_BUSY;
            foreign  <= 1'b0;
            wait_cnt <= '0;
          end else if (!owner_req) begin
            state <= ST_TURN;
            gnt   <= ALL_HIGH;
          end else if (wait_cnt == WAIT_MAX) begin
            // Counter saturates; only revoke when someone else is waiting.
            if (other_req) begin
              state       <= ST_TURN;
              gnt         <= ALL_HIGH;
              timeout_evt <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_BUSY: begin
          if (bus_idle) begin
            if (foreign) begin
              state    <= arb_state;
              owner    <= arb_owner;
              gnt      <= arb_gnt;
              rr_ptr   <= arb_rr;
              wait_cnt <= '0;
              foreign  <= 1'b0;
            end else if (other_req) begin
              state <= ST_TURN;
              gnt   <= ALL_HIGH;
            end else if (owner_req) begin
              // Same master wants it again: keep gnt low, skip turnaround.
              state    <= ST_GRANT;
              wait_cnt <= '0;
              rr_ptr   <= next_idx(owner);
            end else begin
              state <= ST_IDLE;
              gnt   <= ALL_HIGH;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          gnt     <= ALL_HIGH;
          foreign <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Testbench for pci_bus_arbiter: directed scenarios followed by random
// request/frame/irdy traffic, every cycle compared against a behavioural model
// that tracks which master holds the grant.
module tb_pci_bus_arbiter;

  localparam int NM      = 4;
  localparam bit PEN     = 1'b1;
  localparam int PM      = 2;
  localparam int TMO     = 16;

  localparam int M_IDLE  = 0;
  localparam int M_PARK  = 1;
  localparam int M_GRANT = 2;
  localparam int M_BUSY  = 3;
  localparam int M_TURN  = 4;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [NM-1:0] req;
  logic          frame;
  logic          irdy;
  logic [NM-1:0] gnt;
  logic [2:0]    owner;
  logic          bus_busy;
  logic          timeout_evt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pci_bus_arbiter #(
    .N_MASTERS  (NM),
    .PARK_EN    (PEN),
    .PARK_MASTER(PM),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .frame      (frame),
    .irdy       (irdy),
    .gnt        (gnt),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .timeout_evt(timeout_evt)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bus ownership as "who holds the grant" (-1 = nobody).
  int m_mode, m_holder, m_owner, m_rr, m_wait;
  bit m_tevt, m_foreign;

  task automatic model_reset();
    m_mode = M_IDLE; m_holder = -1; m_owner = 0; m_rr = 0; m_wait = 0;
    m_tevt = 1'b0; m_foreign = 1'b0;
  endtask

  function automatic int rr_pick(input logic [NM-1:0] r, input int from);
    for (int i = 0; i < NM; i++) begin
      int k;
      k = (from + i) % NM;
      if (r[k] == 1'b0) return k;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] model_gnt();
    logic [NM-1:0] v;
    for (int k = 0; k < NM; k++) v[k] = (k != m_holder);
    return v;
  endfunction

  task automatic give(input int w);
    m_mode = M_GRANT; m_holder = w; m_owner = w; m_rr = (w + 1) % NM; m_wait = 0;
    m_foreign = 1'b0;
  endtask

  task automatic fresh_arbitration(input logic [NM-1:0] r);
    int w;
    w = rr_pick(r, m_rr);
    m_foreign = 1'b0;
    if (w >= 0) give(w);
    else if (PEN) begin
      m_mode = M_PARK; m_holder = PM; m_owner = PM;
    end else begin
      m_mode = M_IDLE; m_holder = -1;
    end
  endtask

  task automatic model_step(input logic [NM-1:0] r, input logic f, input logic i);
    int  w;
    bit  others;
    w = rr_pick(r, m_rr);
    others = 1'b0;
    for (int k = 0; k < NM; k++) if (k != m_owner && r[k] == 1'b0) others = 1'b1;
    m_tevt = 1'b0;
    case (m_mode)
      M_IDLE, M_TURN: begin
        if (!f) begin
          m_mode = M_BUSY; m_foreign = 1'b1; m_holder = -1;
        end else fresh_arbitration(r);
      end
      M_PARK: begin
        if (!f) begin
          m_mode = M_BUSY; m_foreign = 1'b0;
        end else if (w >= 0 && w != PM) begin
          m_mode = M_TURN; m_holder = -1;
        end else if (r[PM] == 1'b0) give(PM);
      end
      M_GRANT: begin
        if (!f) begin
          m_mode = M_BUSY; m_wait = 0; m_foreign = 1'b0;
        end else if (r[m_owner] == 1'b1) begin
          m_mode = M_TURN; m_holder = -1;
        end else if (m_wait == TMO - 1) begin
          if (others) begin
            m_mode = M_TURN; m_holder = -1; m_tevt = 1'b1;
          end
        end else m_wait++;
      end
      M_BUSY: begin
        if (f && i) begin
          if (m_foreign) fresh_arbitration(r);
          else if (others) begin
            m_mode = M_TURN; m_holder = -1;
          end else if (r[m_owner] == 1'b0) give(m_owner);
          else begin
            m_mode = M_IDLE; m_holder = -1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic check_outputs();
    check("gnt", gnt, model_gnt());
    check("owner", owner, 3'(m_owner));
    check("bus_busy", bus_busy, (m_mode == M_BUSY));
    check("timeout_evt", timeout_evt, m_tevt);
    check("gnt_onehot", ($countones(~gnt) <= 1), 1);
  endtask

  // Drive inputs just after a rising edge; the DUT samples them on the
  // following falling edge; outputs are compared at the next rising edge.
  task automatic step(input logic [NM-1:0] r, input logic f, input logic i);
    req = r; frame = f; irdy = i;
    model_step(r, f, i);
    @(posedge clk);
    check_outputs();
  endtask

  // Assert reset between edges and check the grant drops without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", gnt, 4'b1111);
    check("async_rst_busy", bus_busy, 1'b0);
    check("async_rst_owner", owner, 3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    rst = 1'b0;
  endtask

  function automatic int low_index(input logic [NM-1:0] g);
    for (int k = 0; k < NM; k++) if (g[k] == 1'b0) return k;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NM-1:0] r;
    int            n;
    int            seen;
    logic          f;
    logic          i;

    rst = 1'b1; req = 4'b0000; frame = 1'b1; irdy = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    check("rst_gnt", gnt, 4'b1111);
    check("rst_owner", owner, 3'd0);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_tevt", timeout_evt, 1'b0);
    rst = 1'b0;
    step(4'b0000, 1'b1, 1'b1);
    check("first_grant", gnt, 4'b1110);

    // Masters 0 and 2 alternate, one turnaround cycle between transactions.
    exp_q = '{3'd0, 3'd2, 3'd0, 3'd2};
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (gnt === 4'b1111 && n < 20) begin
        step(4'b1010, 1'b1, 1'b1);
        n++;
      end
      check("alt_wait", (gnt !== 4'b1111), 1);
      seen = low_index(gnt);
      check("alt_order", 3'(seen), exp_q.pop_front());
      repeat (3) step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b1, 1'b1);
      check("alt_turn", gnt, 4'b1111);
    end

    // Master 1 never uses its grant while master 3 waits.
    async_reset();
    step(4'b0101, 1'b1, 1'b1);
    check("tmo_grant1", gnt, 4'b1101);
    n = 0;
    while (gnt === 4'b1101 && n < 40) begin
      n++;
      step(4'b0101, 1'b1, 1'b1);
    end
    check("tmo_cycles", n, 16);
    check("tmo_evt", timeout_evt, 1'b1);
    check("tmo_turn", gnt, 4'b1111);
    step(4'b0101, 1'b1, 1'b1);
    check("tmo_grant3", gnt, 4'b0111);
    check("tmo_evt_once", timeout_evt, 1'b0);

    // Parking on master 2, then master 0 takes over via turnaround.
    async_reset();
    step(4'b1111, 1'b1, 1'b1);
    check("park_gnt", gnt, 4'b1011);
    repeat (3) step(4'b1111, 1'b1, 1'b1);
    check("park_steady", gnt, 4'b1011);
    step(4'b1110, 1'b1, 1'b1);
    check("park_turn", gnt, 4'b1111);
    step(4'b1110, 1'b1, 1'b1);
    check("park_to0", gnt, 4'b1110);

    // Master 0 keeps the bus through its transaction while master 1 waits.
    step(4'b1110, 1'b0, 1'b0);
    check("busy_flag", bus_busy, 1'b1);
    step(4'b1100, 1'b0, 1'b0);
    check("busy_hold", gnt, 4'b1110);
    step(4'b1100, 1'b1, 1'b0);
    check("busy_hold_irdy", gnt, 4'b1110);
    step(4'b1100, 1'b1, 1'b1);
    check("busy_turn", gnt, 4'b1111);
    step(4'b1100, 1'b1, 1'b1);
    check("busy_to1", gnt, 4'b1101);

    // Reset in the middle of a transaction.
    step(4'b1100, 1'b0, 1'b0);
    check("pre_rst_busy", bus_busy, 1'b1);
    async_reset();

    // Random traffic against the model.
    r = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NM; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      f = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      i = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      step(r, f, i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
